// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: access sizes and FSM states.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC0 = 3'd1,
      ACC1 = 3'd2,
      CAP  = 3'd3,
      RESP = 3'd4
   } state_e;

   function automatic int unsigned size_bytes(input logic [1:0] sz);
      return 32'd1 << sz;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Load/store request and response bundle between the CPU side (master) and the unit (slave).
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_access_unit_ram.sv
// Byte-enable single-port synchronous RAM with registered read; contents are never reset.
module mem_be_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [DATA_W/8-1:0]      be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout
);
   localparam int BYTES = DATA_W / 8;

   logic [BYTES-1:0][7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (be[i]) mem[addr][i] <= din[8*i +: 8];
         end
      end
      dout <= mem[addr];
   end
endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store unit over a byte-enable RAM; unaligned accesses that cross a
// RAM word are split into two RAM cycles and the halves are merged before formatting.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int LB    = $clog2(BYTES);
   localparam int WA    = ADDR_W - LB;
   localparam int DEPTH = 1 << WA;
   localparam int CW    = LB + 4;
   localparam int MW    = 2 * BYTES;

   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t   rq;
   state_e state, state_nx;

   logic [LB-1:0]       off;
   logic [WA-1:0]       w0, w1;
   logic [CW-1:0]       nb;
   logic                span;
   logic                err_in;
   logic [MW-1:0]       lmask;
   logic [2*DATA_W-1:0] wsh;

   logic                ram_we;
   logic [BYTES-1:0]    ram_be;
   logic [WA-1:0]       ram_addr;
   logic [DATA_W-1:0]   ram_din, ram_dout;

   logic [DATA_W-1:0]   lo, hi, lo_eff, hi_eff, raw, fmt;
   logic [2*DATA_W-1:0] cat;
   logic                sbit;

   logic                rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;

   assign off    = rq.addr[LB-1:0];
   assign w0     = rq.addr[ADDR_W-1:LB];
   assign w1     = w0 + WA'(1);
   assign nb     = CW'(size_bytes(rq.size));
   assign span   = (CW'(off) + nb) > CW'(BYTES);
   assign err_in = size_bytes(bus.req_size) > unsigned'(BYTES);

   // Lane mask and data laid out across two consecutive words: low half -> w0, high half -> w1.
   assign lmask  = ((MW'(1) << nb) - MW'(1)) << off;
   assign wsh    = {{DATA_W{1'b0}}, rq.wdata} << {off, 3'b000};

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   mem_be_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .be   (ram_be),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ram_we   = 1'b0;
      ram_be   = '0;
      ram_addr = w0;
      ram_din  = '0;
      case (state)
         IDLE: if (bus.req_valid) state_nx = err_in ? RESP : ACC0;
         ACC0: begin
            if (rq.we) begin
               ram_we  = 1'b1;
               ram_be  = lmask[BYTES-1:0];
               ram_din = wsh[DATA_W-1:0];
            end
            if (span)       state_nx = ACC1;
            else if (rq.we) state_nx = RESP;
            else            state_nx = CAP;
         end
         ACC1: begin
            ram_addr = w1;
            if (rq.we) begin
               ram_we  = 1'b1;
               ram_be  = lmask[MW-1:BYTES];
               ram_din = wsh[2*DATA_W-1:DATA_W];
            end
            state_nx = rq.we ? RESP : CAP;
         end
         CAP:     state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The last RAM word is merged combinationally so the result can be registered on entry to RESP.
   always_comb begin
      lo_eff = lo;
      hi_eff = hi;
      if (state == CAP) begin
         if (span) hi_eff = ram_dout;
         else      lo_eff = ram_dout;
      end
      cat  = {hi_eff, lo_eff} >> {off, 3'b000};
      raw  = cat[DATA_W-1:0];
      sbit = 1'b0;
      for (int k = 0; k < BYTES; k++) begin
         if (CW'(k + 1) == nb) sbit = raw[8*k+7];
      end
      fmt = '0;
      for (int k = 0; k < BYTES; k++) begin
         fmt[8*k +: 8] = (CW'(k) < nb) ? raw[8*k +: 8] : {8{rq.sgn & sbit}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq          <= '0;
         lo          <= '0;
         hi          <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            rq <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                    addr: bus.req_addr, wdata: bus.req_wdata};
         end
         if (state == ACC1 && !rq.we) lo <= ram_dout;
         if (state == CAP) begin
            if (span) hi <= ram_dout;
            else      lo <= ram_dout;
         end
         rsp_valid_q <= (state_nx == RESP);
         rsp_err_q   <= (state == IDLE) && (state_nx == RESP);
         rsp_rdata_q <= (state == CAP) ? fmt : '0;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver pushes expected responses, a monitor pops and compares.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(12)) bus();

   mem_access_unit #(.DATA_W(32), .ADDR_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h required no response (t=%0t)",
                     bus.rsp_rdata, $time);
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                      input bit push);
      int t;
      t = 0;
      @(negedge clk);
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      while (!bus.req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL req_ready_timeout: got req_ready=0 required 1 within 50 cycles");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (push) sb.push_back('{exp_rdata, exp_err, lat, cyc});
      bus.req_valid = 1'b0;
   endtask

   task automatic st(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] d, input int lat);
      req(1'b1, size, 1'b0, addr, d, 32'h0, 1'b0, lat, 1'b1);
   endtask

   task automatic ld(input logic [1:0] size, input logic sgn, input logic [11:0] addr,
                     input logic [31:0] exp, input int lat);
      req(1'b0, size, sgn, addr, 32'h0, exp, 1'b0, lat, 1'b1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL rsp_timeout: got %0d responses outstanding required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd1);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      rst = 1'b0;

      // aligned stores, then a spanning word load
      st(2'd2, 12'h000, 32'h11223344, 2);
      st(2'd2, 12'h004, 32'h55667788, 2);
      ld(2'd2, 1'b0, 12'h001, 32'h88112233, 4);
      drain();

      // reset while the spanning load sits in ACC1: no response, ready straight after
      req(1'b0, 2'd2, 1'b0, 12'h001, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (5) begin
         check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
         @(negedge clk);
      end
      ld(2'd2, 1'b0, 12'h001, 32'h88112233, 4);

      // byte store and sign/zero extension
      st(2'd0, 12'h006, 32'h000000AB, 2);
      ld(2'd2, 1'b0, 12'h004, 32'h55AB7788, 3);
      ld(2'd0, 1'b1, 12'h006, 32'hFFFFFFAB, 3);
      ld(2'd0, 1'b0, 12'h006, 32'h000000AB, 3);

      // spanning half store
      st(2'd1, 12'h003, 32'h0000BEEF, 3);
      ld(2'd2, 1'b0, 12'h000, 32'hEF223344, 3);
      ld(2'd2, 1'b0, 12'h004, 32'h55AB77BE, 3);

      // wrap from the last byte to address 0
      st(2'd2, 12'hFFF, 32'hCAFEF00D, 3);
      ld(2'd0, 1'b0, 12'hFFF, 32'h0000000D, 3);
      ld(2'd2, 1'b0, 12'h000, 32'hEFCAFEF0, 3);
      ld(2'd1, 1'b1, 12'hFFF, 32'hFFFFF00D, 4);

      // oversize access errors out without touching memory
      req(1'b1, 2'd3, 1'b0, 12'h004, 32'hDEADBEEF, 32'h0, 1'b1, 1, 1'b1);
      req(1'b0, 2'd3, 1'b1, 12'h004, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      ld(2'd2, 1'b0, 12'h004, 32'h55AB77BE, 3);
      drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
